ec_scalar_mul: RTL and testbench



---
 rtl/ec_pkg.sv | 25 ++
 rtl/ec_msb_find.sv | 17 +
 rtl/ec_scalar_mul.sv | 178 +++++++++++++++++
 tb/tb_ec_scalar_mul.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ec_pkg.sv
// Shared defaults, FSM state encoding and affine point type for the EC scalar multiplier.
package ec_pkg;

  localparam int W_DEF   = 6;
  localparam int K_W_DEF = 6;

  typedef enum logic [3:0] {
    IDLE,
    SCAN,
    DBL,
    DBL_WAIT,
    ADD,
    ADD_WAIT,
    WAIT_LOW,
    NEXT,
    DONE
  } state_t;

  typedef struct packed {
    logic [W_DEF-1:0] x;
    logic [W_DEF-1:0] y;
    logic             inf;
  } point_t;

endpackage

// File: rtl/ec_msb_find.sv
// Combinational leading-one finder: index of the highest set bit of k (0 when k is 0).
module ec_msb_find #(
  parameter int K_W   = 6,
  parameter int IDX_W = 3
) (
  input  logic [K_W-1:0]   k,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < K_W; i++) begin
      if (k[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/ec_scalar_mul.sv
// Left-to-right double-and-add scalar multiplier driving an external point adder.
// Optional adder watchdog with out_err port: define ECSM_TIMEOUT_EN.
module ec_scalar_mul
  import ec_pkg::*;
#(
  parameter int W       = W_DEF,
`ifdef ECSM_TIMEOUT_EN
  parameter int TIMEOUT = 64,
`endif
  parameter int K_W     = K_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [W-1:0]   in_Px,
  input  logic [W-1:0]   in_Py,
  input  logic [K_W-1:0] in_k,
  input  logic [W-1:0]   in_prime,
  input  logic [W-1:0]   in_a,
  output logic           pa_in_valid,
  output logic [W-1:0]   pa_Px,
  output logic [W-1:0]   pa_Py,
  output logic [W-1:0]   pa_Qx,
  output logic [W-1:0]   pa_Qy,
  output logic [W-1:0]   pa_prime,
  output logic [W-1:0]   pa_a,
  input  logic           pa_out_valid,
  input  logic [W-1:0]   pa_Rx,
  input  logic [W-1:0]   pa_Ry,
  output logic           busy,
  output logic           out_valid,
  output logic [W-1:0]   out_Rx,
  output logic [W-1:0]   out_Ry,
`ifdef ECSM_TIMEOUT_EN
  output logic           out_inf,
  output logic           out_err
`else
  output logic           out_inf
`endif
);

  localparam int IDX_W = (K_W > 1) ? $clog2(K_W) : 1;

  state_t            state, state_nxt;
  point_t            acc, base;
  logic [K_W-1:0]    k_r;
  logic [W-1:0]      prime_r, a_r;
  logic [IDX_W-1:0]  idx, msb_idx;
  logic              from_add, add_dbl;
  logic              add_is_dbl, issue_dbl, issue_add;
  logic              req_any, req_dbl;
  logic              timeout, err;

  ec_msb_find #(.K_W(K_W), .IDX_W(IDX_W)) u_msb (
    .k   (k_r),
    .idx (msb_idx)
  );

  // acc == P with y == 0 doubles to infinity, so that case is resolved locally
  assign add_is_dbl = (acc.x == base.x) && (acc.y == base.y);
  assign issue_dbl  = (state == DBL) && !acc.inf && (acc.y != '0);
  assign issue_add  = (state == ADD) && !acc.inf &&
                      ((acc.x != base.x) || (add_is_dbl && (acc.y != '0)));

`ifdef ECSM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt;
  logic             stalled;

  assign stalled = (((state == DBL_WAIT) || (state == ADD_WAIT)) && !pa_out_valid) ||
                   ((state == WAIT_LOW) && pa_out_valid);
  assign timeout = stalled && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= (state_nxt != state) ? '0 : (stalled ? cnt + 1'b1 : '0);
      if (state == IDLE && in_valid) err <= 1'b0;
      else if (timeout)              err <= 1'b1;
    end
  end

  assign out_err = (state == DONE) && err;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      from_add <= 1'b0;
      add_dbl  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == DBL) from_add <= 1'b0;
      if (state == ADD) begin
        from_add <= 1'b1;
        add_dbl  <= add_is_dbl;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (in_valid) state_nxt = SCAN;
      SCAN:     state_nxt = ((k_r == '0) || (msb_idx == '0)) ? DONE : DBL;
      DBL:      state_nxt = issue_dbl ? DBL_WAIT : (k_r[idx] ? ADD : NEXT);
      DBL_WAIT,
      ADD_WAIT: begin
        if (pa_out_valid) state_nxt = WAIT_LOW;
        else if (timeout) state_nxt = DONE;
      end
      ADD:      state_nxt = issue_add ? ADD_WAIT : NEXT;
      WAIT_LOW: begin
        if (!pa_out_valid) state_nxt = (from_add || !k_r[idx]) ? NEXT : ADD;
        else if (timeout)  state_nxt = DONE;
      end
      NEXT:     state_nxt = (idx == '0) ? DONE : DBL;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Datapath registers carry no reset; every job reloads them in IDLE/SCAN
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (in_valid) begin
          base    <= '{x: in_Px, y: in_Py, inf: 1'b0};
          k_r     <= in_k;
          prime_r <= in_prime;
          a_r     <= in_a;
        end
      end
      SCAN: begin
        acc <= '{x: base.x, y: base.y, inf: (k_r == '0)};
        idx <= msb_idx - 1'b1;
      end
      DBL:      if (!acc.inf && (acc.y == '0)) acc.inf <= 1'b1;
      DBL_WAIT,
      ADD_WAIT: begin
        if (pa_out_valid) begin
          acc.x <= pa_Rx;
          acc.y <= pa_Ry;
        end
      end
      ADD: begin
        if (acc.inf)                                 acc     <= base;
        else if (!issue_add && (acc.x == base.x))    acc.inf <= 1'b1;
      end
      NEXT:     if (idx != '0) idx <= idx - 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pa_in_valid = issue_dbl || issue_add;
    req_any     = pa_in_valid || (state == DBL_WAIT) || (state == ADD_WAIT);
    req_dbl     = issue_dbl || (state == DBL_WAIT) ||
                  (issue_add && add_is_dbl) || ((state == ADD_WAIT) && add_dbl);
    pa_Px       = req_any ? acc.x : '0;
    pa_Py       = req_any ? acc.y : '0;
    pa_Qx       = req_any ? (req_dbl ? acc.x : base.x) : '0;
    pa_Qy       = req_any ? (req_dbl ? acc.y : base.y) : '0;
    pa_prime    = req_any ? prime_r : '0;
    pa_a        = req_any ? a_r : '0;
    busy        = (state != IDLE) && (state != DONE);
    out_valid   = (state == DONE);
    out_Rx      = (out_valid && !acc.inf && !err) ? acc.x : '0;
    out_Ry      = (out_valid && !acc.inf && !err) ? acc.y : '0;
    out_inf     = out_valid && acc.inf && !err;
  end

endmodule

// File: tb/tb_ec_scalar_mul.sv
// Bench for ec_scalar_mul on y^2 = x^3 + 2x + 2 mod 17 with a behavioural point-adder model.
`timescale 1ns/1ps
module tb_ec_scalar_mul;

  localparam int W     = 6;
  localparam int K_W   = 6;
  localparam int LAT   = 3;
  localparam int PRIME = 17;
  localparam int CA    = 2;
  localparam int PX    = 5;
  localparam int PY    = 1;

  typedef struct {
    int x;
    int y;
    bit inf;
  } pt_s;

  logic           clk = 1'b0;
  logic           rst_n, in_valid;
  logic [W-1:0]   in_Px, in_Py, in_prime, in_a;
  logic [K_W-1:0] in_k;
  logic           pa_in_valid;
  logic [W-1:0]   pa_Px, pa_Py, pa_Qx, pa_Qy, pa_prime, pa_a;
  logic           pa_out_valid = 1'b0;
  logic [W-1:0]   pa_Rx = '0, pa_Ry = '0;
  logic           busy, out_valid, out_inf;
  logic [W-1:0]   out_Rx, out_Ry;
`ifdef ECSM_TIMEOUT_EN
  logic           out_err;
`endif

  always #5 clk = ~clk;

  ec_scalar_mul dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_Px(in_Px), .in_Py(in_Py), .in_k(in_k), .in_prime(in_prime), .in_a(in_a),
    .pa_in_valid(pa_in_valid), .pa_Px(pa_Px), .pa_Py(pa_Py), .pa_Qx(pa_Qx), .pa_Qy(pa_Qy),
    .pa_prime(pa_prime), .pa_a(pa_a), .pa_out_valid(pa_out_valid), .pa_Rx(pa_Rx), .pa_Ry(pa_Ry),
    .busy(busy), .out_valid(out_valid), .out_Rx(out_Rx), .out_Ry(out_Ry),
`ifdef ECSM_TIMEOUT_EN
    .out_inf(out_inf), .out_err(out_err)
`else
    .out_inf(out_inf)
`endif
  );

  int  n_checks = 0;
  int  n_fail   = 0;
  pt_s sb[$];

  function automatic int modinv(int d, int p);
    for (int i = 1; i < p; i++) if (((d * i) % p) == 1) return i;
    return 0;
  endfunction

  function automatic pt_s pt_add(pt_s a, pt_s b, int p, int ca);
    pt_s r;
    int num, den, lam, t;
    r = '{0, 0, 1'b1};
    if (a.inf) return b;
    if (b.inf) return a;
    if (a.x == b.x && (a.y != b.y || a.y == 0)) return r;
    if (a.x == b.x) begin
      num = (3 * a.x * a.x + ca) % p;
      den = (2 * a.y) % p;
    end else begin
      num = (b.y - a.y + p) % p;
      den = (b.x - a.x + p) % p;
    end
    lam   = (num * modinv(den, p)) % p;
    r.x   = (lam * lam + 2 * p - a.x - b.x) % p;
    t     = (lam * ((a.x - r.x + p) % p)) % p;
    r.y   = (t - a.y + p) % p;
    r.inf = 1'b0;
    return r;
  endfunction

  // Reference by repeated addition, independent of the double-and-add schedule
  function automatic pt_s ref_mul(int k);
    pt_s acc, p;
    acc = '{0, 0, 1'b1};
    p   = '{PX, PY, 1'b0};
    for (int i = 0; i < k; i++) acc = pt_add(acc, p, PRIME, CA);
    return acc;
  endfunction

  // Adder model: result LAT cycles after the request, valid held for two cycles
  logic pend = 1'b0;
  int   cyc = 0;
  int   req_cnt = 0;
  int   bad_req = 0;
  pt_s  res = '{0, 0, 1'b0};

  always @(posedge clk) begin
    if (pa_in_valid) begin
      req_cnt <= req_cnt + 1;
      if (pend || (pa_Px == pa_Qx && (pa_Py != pa_Qy || pa_Py == '0)))
        bad_req <= bad_req + 1;
      res  <= pt_add('{int'(pa_Px), int'(pa_Py), 1'b0}, '{int'(pa_Qx), int'(pa_Qy), 1'b0},
                     int'(pa_prime), int'(pa_a));
      pend <= 1'b1;
      cyc  <= 0;
    end else if (pend) begin
      cyc <= cyc + 1;
      if (cyc == LAT - 1) begin
        pa_out_valid <= 1'b1;
        pa_Rx        <= W'(res.x);
        pa_Ry        <= W'(res.y);
      end
      if (cyc == LAT + 1) begin
        pa_out_valid <= 1'b0;
        pa_Rx        <= '0;
        pa_Ry        <= '0;
        pend         <= 1'b0;
      end
    end
  end

  task automatic start_job(input int k, input pt_s e);
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b1;
    in_k     = K_W'(k);
    in_Px    = W'(PX);
    in_Py    = W'(PY);
    in_prime = W'(PRIME);
    in_a     = W'(CA);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int limit, output bit got, output int n);
    got = 1'b0;
    n   = 0;
    for (int i = 0; i < limit && !got; i++) begin
      if (out_valid) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({out_valid, busy, pa_in_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, want 000", {out_valid, busy, pa_in_valid});
    end
    n_checks++;
    if ({pa_Px, pa_Py, pa_Qx, pa_Qy, pa_prime, pa_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_pa: got %h, want 0", {pa_Px, pa_Py, pa_Qx, pa_Qy, pa_prime, pa_a});
    end
    n_checks++;
    if ({out_Rx, out_Ry, out_inf} !== '0) begin
      n_fail++;
      $display("FAIL reset_out: got %h, want 0", {out_Rx, out_Ry, out_inf});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_k1;
    bit got; int n, r0; pt_s e;
    r0 = req_cnt;
    start_job(1, '{5, 1, 1'b0});
    wait_out(200, got, n);
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL k1_done: no out_valid within 200 cycles");
    end else begin
      e = sb.pop_front();
      if ({out_Rx, out_Ry, out_inf, busy} !== {W'(e.x), W'(e.y), e.inf, 1'b0}) begin
        n_fail++;
        $display("FAIL k1_result: got (%0d,%0d) inf=%b busy=%b, want (%0d,%0d) inf=%b busy=0",
                 out_Rx, out_Ry, out_inf, busy, e.x, e.y, e.inf);
      end
    end
    n_checks++;
    if (req_cnt - r0 != 0) begin
      n_fail++;
      $display("FAIL k1_requests: got %0d, want 0", req_cnt - r0);
    end
  endtask

  task automatic test_double;
    bit got; int n, r0; pt_s e;
    r0 = req_cnt;
    start_job(2, '{6, 3, 1'b0});
    wait_out(200, got, n);
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL k2_done: no out_valid within 200 cycles");
    end else begin
      e = sb.pop_front();
      if ({out_Rx, out_Ry, out_inf} !== {W'(e.x), W'(e.y), e.inf}) begin
        n_fail++;
        $display("FAIL k2_result: got (%0d,%0d) inf=%b, want (%0d,%0d) inf=%b",
                 out_Rx, out_Ry, out_inf, e.x, e.y, e.inf);
      end
    end
    n_checks++;
    if (req_cnt - r0 != 1) begin
      n_fail++;
      $display("FAIL k2_requests: got %0d, want 1", req_cnt - r0);
    end
  endtask

  task automatic test_dbl_add;
    bit got; int n, r0; pt_s e;
    r0 = req_cnt;
    start_job(5, '{9, 16, 1'b0});
    wait_out(300, got, n);
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL k5_done: no out_valid within 300 cycles");
    end else begin
      e = sb.pop_front();
      if ({out_Rx, out_Ry, out_inf} !== {W'(e.x), W'(e.y), e.inf}) begin
        n_fail++;
        $display("FAIL k5_result: got (%0d,%0d) inf=%b, want (%0d,%0d) inf=%b",
                 out_Rx, out_Ry, out_inf, e.x, e.y, e.inf);
      end
    end
    n_checks++;
    if (req_cnt - r0 != 3) begin
      n_fail++;
      $display("FAIL k5_requests: got %0d, want 3", req_cnt - r0);
    end
  endtask

  task automatic test_local_inf;
    bit got; int n; pt_s e;
    start_job(19, '{0, 0, 1'b1});
    wait_out(400, got, n);
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL k19_done: no out_valid within 400 cycles");
    end else begin
      e = sb.pop_front();
      if ({out_Rx, out_Ry, out_inf} !== {W'(e.x), W'(e.y), e.inf}) begin
        n_fail++;
        $display("FAIL k19_result: got (%0d,%0d) inf=%b, want (0,0) inf=1", out_Rx, out_Ry, out_inf);
      end
    end
  endtask

  task automatic test_k0;
    bit got; int n, r0; pt_s e;
    r0 = req_cnt;
    start_job(0, '{0, 0, 1'b1});
    wait_out(10, got, n);
    n_checks++;
    if (!got || n + 1 > 3) begin
      n_fail++;
      $display("FAIL k0_latency: got=%b cycles=%0d, want out_valid within 3", got, n + 1);
    end
    if (got) begin
      e = sb.pop_front();
      n_checks++;
      if ({out_Rx, out_Ry, out_inf} !== {W'(e.x), W'(e.y), e.inf}) begin
        n_fail++;
        $display("FAIL k0_result: got (%0d,%0d) inf=%b, want (0,0) inf=1", out_Rx, out_Ry, out_inf);
      end
    end
    n_checks++;
    if (req_cnt - r0 != 0) begin
      n_fail++;
      $display("FAIL k0_requests: got %0d, want 0", req_cnt - r0);
    end
  endtask

  task automatic test_busy_ignore;
    bit got; int n, extra; pt_s e;
    start_job(5, '{9, 16, 1'b0});
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    in_k     = K_W'(1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(300, got, n);
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL busy_done: no out_valid within 300 cycles");
    end else begin
      e = sb.pop_front();
      if ({out_Rx, out_Ry, out_inf} !== {W'(e.x), W'(e.y), e.inf}) begin
        n_fail++;
        $display("FAIL busy_result: got (%0d,%0d) inf=%b, want (9,16) inf=0", out_Rx, out_Ry, out_inf);
      end
    end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL busy_extra: got %0d extra out_valid, want 0", extra);
    end
  endtask

  task automatic test_sweep;
    int  ks[12] = '{3, 4, 6, 7, 9, 12, 17, 18, 20, 31, 38, 63};
    bit  got; int n, r0; pt_s e;
    foreach (ks[i]) begin
      r0 = req_cnt;
      start_job(ks[i], ref_mul(ks[i]));
      wait_out(500, got, n);
      n_checks++;
      if (!got) begin
        n_fail++;
        $display("FAIL sweep_done k=%0d: no out_valid within 500 cycles", ks[i]);
        sb.delete();
      end else begin
        e = sb.pop_front();
        if ({out_Rx, out_Ry, out_inf} !== {W'(e.x), W'(e.y), e.inf}) begin
          n_fail++;
          $display("FAIL sweep_result k=%0d: got (%0d,%0d) inf=%b, want (%0d,%0d) inf=%b",
                   ks[i], out_Rx, out_Ry, out_inf, e.x, e.y, e.inf);
        end
      end
      n_checks++;
      if (req_cnt - r0 > 2 * (K_W - 1)) begin
        n_fail++;
        $display("FAIL sweep_requests k=%0d: got %0d, want <= %0d", ks[i], req_cnt - r0, 2 * (K_W - 1));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midjob;
    bit got, seen; int n, stray; pt_s e;
    start_job(18, '{5, 16, 1'b0});
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (pa_in_valid) seen = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL midrst_request: no pa_in_valid within 50 cycles");
    end
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    n_checks++;
    if ({out_valid, busy, pa_in_valid, pa_Px, pa_Py, pa_Qx, pa_Qy, out_Rx, out_Ry, out_inf} !== '0) begin
      n_fail++;
      $display("FAIL midrst_zero: got %h, want 0",
               {out_valid, busy, pa_in_valid, pa_Px, pa_Py, pa_Qx, pa_Qy, out_Rx, out_Ry, out_inf});
    end
    rst_n = 1'b1;
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid || busy || pa_in_valid) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL midrst_stale: got %0d active cycles after reset, want 0", stray);
    end
    start_job(18, '{5, 16, 1'b0});
    wait_out(400, got, n);
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL midrst_done: no out_valid within 400 cycles");
    end else begin
      e = sb.pop_front();
      if ({out_Rx, out_Ry, out_inf} !== {W'(e.x), W'(e.y), e.inf}) begin
        n_fail++;
        $display("FAIL midrst_result: got (%0d,%0d) inf=%b, want (5,16) inf=0", out_Rx, out_Ry, out_inf);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_k     = '0;
    in_Px    = '0;
    in_Py    = '0;
    in_prime = '0;
    in_a     = '0;
    test_reset;
    test_k1;
    test_double;
    test_dbl_add;
    test_local_inf;
    test_k0;
    test_busy_ignore;
    test_sweep;
    test_reset_midjob;
    n_checks++;
    if (bad_req != 0) begin
      n_fail++;
      $display("FAIL adder_operands: got %0d illegal requests, want 0", bad_req);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
